// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data memory arbiter
package mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_CORE = 2'd1,
        RESP_DMA  = 2'd2
    } resp_state_e;

    typedef struct packed {
        logic              we;
        logic [2:0]        func3;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_prio_sel.sv
// rtl/dmem_prio_sel.sv - two-way priority select, core first unless DMA is starved
module dmem_prio_sel (
    input  logic i_core_req,
    input  logic i_dma_req,
    input  logic i_dma_force,
    output logic o_core_gnt,
    output logic o_dma_gnt
);

    // Core wins ties unless the starvation flag hands the slot to DMA.
    always_comb begin
        o_core_gnt = i_core_req & ~(i_dma_req & i_dma_force);
        o_dma_gnt  = i_dma_req & (~i_core_req | i_dma_force);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA arbiter and response sequencer for data memory
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [2:0]    core_func3,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [2:0]    mem_func3,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]    r_wait_cnt;
    resp_state_e   r_state;
    resp_state_e   w_state_nxt;
    logic          w_dma_force;
    logic          w_core_gnt;
    logic          w_dma_gnt;
    logic          w_any_gnt;
    mem_req_t      w_core_rq;
    mem_req_t      w_dma_rq;
    mem_req_t      w_sel;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_dma_rdata;

    assign w_dma_force = (r_wait_cnt == LP_MAX_WAIT);

    dmem_prio_sel u_prio_sel (
        .i_core_req  (core_req),
        .i_dma_req   (dma_req),
        .i_dma_force (w_dma_force),
        .o_core_gnt  (w_core_gnt),
        .o_dma_gnt   (w_dma_gnt)
    );

    assign w_any_gnt  = w_core_gnt | w_dma_gnt;
    assign core_gnt   = w_core_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign core_stall = core_req & ~w_core_gnt;

    // Pack both requesters and route the winner to memory; idle bus is all zero.
    always_comb begin
        w_core_rq = '{we: core_we, func3: core_func3, addr: core_addr, wdata: core_wdata};
        w_dma_rq  = '{we: dma_we, func3: F3_LW, addr: dma_addr, wdata: dma_wdata};
        w_sel     = '0;
        if (w_core_gnt) begin
            w_sel = w_core_rq;
        end else if (w_dma_gnt) begin
            w_sel = w_dma_rq;
        end
        mem_read  = w_any_gnt & ~w_sel.we;
        mem_write = w_any_gnt & w_sel.we;
        mem_func3 = w_sel.func3;
        mem_addr  = w_sel.addr;
        mem_wdata = w_sel.wdata;
    end

    // Starvation counter: counts lost DMA cycles, saturating at the force level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (w_dma_gnt || !dma_req) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Next response owner: only reads produce a response.
    always_comb begin
        w_state_nxt = RESP_IDLE;
        if (w_core_gnt && !core_we) begin
            w_state_nxt = RESP_CORE;
        end else if (w_dma_gnt && !dma_we) begin
            w_state_nxt = RESP_DMA;
        end
    end

    // Response owner register; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture read data for the owner; the other side keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (w_state_nxt == RESP_CORE) begin
                r_core_rdata <= mem_rdata;
            end
            if (w_state_nxt == RESP_DMA) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    assign core_rvalid = (r_state == RESP_CORE);
    assign dma_rvalid  = (r_state == RESP_DMA);
    assign core_rdata  = r_core_rdata;
    assign dma_rdata   = r_dma_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data memory. It shares the memory between the pipeline MEM stage (core port) and a DMA/debug port. It drives the memory's address, write-data, read/write enables and func3. It registers load data toward the winner and stalls the core when the core loses arbitration. The block sits between the MEM stage / DMA engine and data_mem.

Parameters:
AW, 32, address width on all ports
DW, 32, data width on all ports
MAX_WAIT, 4, consecutive cycles a pending DMA request may lose to the core before DMA is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core access request, held until granted
core_we  in  1  1 = store, 0 = load
core_func3  in  3  load/store size code, forwarded to memory
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_gnt  out  1  core access issued this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core load data valid (registered)
core_rdata  out  DW  core load data (registered)
dma_req  in  1  DMA request, held until granted
dma_we  in  1  1 = write, 0 = read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  DMA read data valid (registered)
dma_rdata  out  DW  DMA read data (registered)
mem_read  out  1  to data_mem
mem_write  out  1  to data_mem
mem_func3  out  3  to data_mem; 3'b010 for DMA accesses
mem_addr  out  AW  to data_mem
mem_wdata  out  DW  to data_mem
mem_rdata  in  DW  combinational read data from data_mem

Behaviour:
- Memory contract: combinational read in the grant cycle; write commits at the clk edge ending the grant cycle.
- Arbitration is combinational and per cycle; at most one grant per cycle.
  - Only one requester asserted: that requester wins.
  - Both asserted: DMA wins if wait_cnt == MAX_WAIT, otherwise the core wins.
  - Neither asserted: no grant. mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, mem_func3 = 0.
- Winner's fields are muxed onto the mem_* outputs.
  - mem_read = ~we and mem_write = we, asserted only for the winner.
- wait_cnt (4-bit register, starvation counter):
  - Cleared when dma_gnt or ~dma_req.
  - Incremented when dma_req & ~dma_gnt, saturating at MAX_WAIT.
- FSM, registered response owner: RESP_IDLE, RESP_CORE, RESP_DMA.
  - Next state is RESP_CORE on a core load grant, RESP_DMA on a DMA read grant, else RESP_IDLE.
  - Stores and writes produce no response.
- Response, registered at the edge ending the grant cycle (latency 1):
  - Owner's rvalid = 1 for exactly one cycle; owner's rdata = mem_rdata captured.
  - The non-owner's rdata holds its previous value.
- Back-to-back grants are allowed every cycle; responses pipeline one behind.
- Same-cycle request drop: a requester that deasserts req in the same cycle it would win receives no grant. No partial access occurs.
- core_stall is combinational; the pipeline freezes MEM while core_stall = 1.
- Reset (async, rst_n = 0), including mid-operation:
  - wait_cnt = 0, FSM = RESP_IDLE.
  - core_rvalid = dma_rvalid = 0, core_rdata = dma_rdata = 0.
  - Any in-flight response is discarded.
  - Grant and mem_* outputs follow the combinational rules; inputs are don't-care during reset, and the bench holds reqs low.
- No address range checking; out-of-range addresses pass through unchanged.

Decomposition:
- Shared package mem_pkg:
  - typedef resp_state_e {RESP_IDLE, RESP_CORE, RESP_DMA}.
  - Constants F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101.
  - Packed struct mem_req_t {we, func3, addr, wdata}.
- One sub-module: dmem_prio_sel, the combinational two-way priority select from reqs and the wait_cnt == MAX_WAIT flag.
- Counter, FSM and response registers stay in the top level.

Test Plan:
1. Reset then core load only: core_req = 1, we = 0, addr = 8, func3 = 010, mem[8] = 32'hDEADBEEF -> core_gnt = 1 and mem_read = 1 the same cycle; next cycle core_rvalid = 1, core_rdata = 32'hDEADBEEF; dma_rvalid = 0.
2. Core store then DMA read of the same address: core writes 32'h1234_5678 to addr 5 in cycle 0, dma_req read addr 5 in cycle 1 -> dma_gnt in cycle 1, dma_rvalid in cycle 2 with 32'h1234_5678, mem_func3 = 010.
3. Starvation with MAX_WAIT = 4: core_req and dma_req both held high -> core_gnt for 4 cycles with core_stall = 0; in the 5th cycle dma_gnt = 1, core_stall = 1, wait_cnt returns to 0; core wins the following cycle.
4. Back-to-back core loads to addrs 1, 2, 3 over 3 cycles -> core_rvalid high for 3 consecutive cycles, one cycle delayed, with data in order.
5. Reset mid-operation: core load granted, rst_n pulled low before the next edge -> core_rvalid stays 0, rdata = 0, wait_cnt = 0 after release.
6. Idle: both reqs low -> mem_read = mem_write = 0, no rvalid, memory contents unchanged over 10 cycles.
